sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_ctrl_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/sram_port_arbiter.sv | 58 +++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: default geometry and request record shared by the SRAM port arbiter.
package sram_ctrl_pkg;
  localparam int DEF_WIDTH = 128;
  localparam int DEF_NUM_ROWS = 4096;
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_AW = $clog2(DEF_NUM_ROWS);
  typedef struct packed {
    logic write;
    logic [DEF_AW-1:0] addr;
    logic [DEF_WIDTH-1:0] wdata;
    logic [DEF_WIDTH-1:0] wbe;
  } req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over N requesters; the pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  valid,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && valid[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM macro among NUM_REQ requesters, round-robin, 1-cycle read latency.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int AW = $clog2(NUM_ROWS),
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ-1:0][AW-1:0]      req_addr,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_wbe,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [WIDTH-1:0]                rsp_rdata,
  output logic                            sram_ceb,
  output logic                            sram_web,
  output logic [AW-1:0]                   sram_a,
  output logic [WIDTH-1:0]                sram_d,
  output logic [WIDTH-1:0]                sram_m,
  input  logic [WIDTH-1:0]                sram_q
);
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] idx, rsp_idx;
  logic any, wr, rsp_v;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .valid(rst_n ? req_valid : '0),
    .advance(any),
    .grant(grant),
    .idx(idx)
  );
  assign req_ready = grant;
  assign any = |grant;
  assign wr = any & req_write[idx];
  assign sram_ceb = ~any;
  assign sram_web = ~wr;
  assign sram_a = any ? req_addr[idx] : '0;
  assign sram_d = wr ? req_wdata[idx] : '0;
  assign sram_m = wr ? ~req_wbe[idx] : '1;
  always_ff @(posedge clk)
    if (!rst_n) begin
      rsp_v <= 1'b0;
      rsp_idx <= '0;
    end else begin
      rsp_v <= any & ~req_write[idx];
      rsp_idx <= idx;
    end
  // gating with rst_n drops a read accepted just before reset asserts
  assign rsp_valid = (rst_n && rsp_v) ? NUM_REQ'(1) << rsp_idx : '0;
  assign rsp_rdata = sram_q;
endmodule
